// File: rtl/icache_axi_param_if.sv
// Fetch, invalidate, relocation and AXI read bundle for icache_axi_param; stats ports exist with ICACHE_STATS_EN.
// slave = the cache, master = the pipeline/memory side driving it.
interface icache_axi_param_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              resp_valid;
    logic [31:0]       resp_data;
    logic              inval_valid;
    logic              inval_all;
    logic [ADDR_W-1:0] inval_addr;
    logic              mem_start_valid;
    logic [ADDR_W-1:0] mem_start_input;
    logic [1:0]        error;
    logic              mem_i_arvalid;
    logic              mem_i_arready;
    logic [ADDR_W-1:0] mem_i_araddr;
    logic [7:0]        mem_i_arlen;
    logic [2:0]        mem_i_arsize;
    logic [1:0]        mem_i_arburst;
    logic              mem_i_rvalid;
    logic              mem_i_rready;
    logic [31:0]       mem_i_rdata;
    logic [1:0]        mem_i_rresp;
    logic              mem_i_rlast;
`ifdef ICACHE_STATS_EN
    logic [31:0]       hit_count;
    logic [31:0]       miss_count;
`endif

    modport slave (
        input  req_valid, req_addr, inval_valid, inval_all, inval_addr,
        input  mem_start_valid, mem_start_input,
        input  mem_i_arready, mem_i_rvalid, mem_i_rdata, mem_i_rresp, mem_i_rlast,
        output req_ready, resp_valid, resp_data, error,
        output mem_i_arvalid, mem_i_araddr, mem_i_arlen, mem_i_arsize, mem_i_arburst, mem_i_rready
`ifdef ICACHE_STATS_EN
        , output hit_count, miss_count
`endif
    );

    modport master (
        output req_valid, req_addr, inval_valid, inval_all, inval_addr,
        output mem_start_valid, mem_start_input,
        output mem_i_arready, mem_i_rvalid, mem_i_rdata, mem_i_rresp, mem_i_rlast,
        input  req_ready, resp_valid, resp_data, error,
        input  mem_i_arvalid, mem_i_araddr, mem_i_arlen, mem_i_arsize, mem_i_arburst, mem_i_rready
`ifdef ICACHE_STATS_EN
        , input hit_count, miss_count
`endif
    );
endinterface

// File: rtl/icache_axi_param.sv
// Direct-mapped I-cache with mem_start relocation and single-burst AXI line refill; ICACHE_STATS_EN adds hit/miss counters.
// Latency: hit response 1 cycle after accept, miss response 1 cycle after the last R beat.
// Backpressure: req_ready only in IDLE; no response backpressure; rready tied high, stray beats dropped.
module icache_axi_param #(
    parameter int ADDR_W     = 32,
    parameter int INDEX_BITS = 10,
    parameter int LINE_WORDS = 16
) (
    input  logic               clk,
    input  logic               resetn,
    icache_axi_param_if.slave  bus
);
    localparam int WB     = $clog2(LINE_WORDS);
    localparam int OB     = WB + 2;
    localparam int TAG_W  = ADDR_W - INDEX_BITS - OB;
    localparam int LINES  = 1 << INDEX_BITS;
    localparam int LINE_W = TAG_W + 32 * LINE_WORDS;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOOKUP  = 3'd1;
    localparam logic [2:0] S_MISS_AR = 3'd2;
    localparam logic [2:0] S_MISS_R  = 3'd3;
    localparam logic [2:0] S_FILL    = 3'd4;
    localparam logic [2:0] S_ERROR   = 3'd5;

    logic [2:0]                  state_q, state_d;
    logic [ADDR_W-1:0]           pa_q, pa_d;
    logic [ADDR_W-1:0]           mem_start_q, mem_start_d;
    logic [LINES-1:0]            valid_q, valid_d;
    logic [LINE_WORDS-1:0][31:0] lbuf_q, lbuf_d;
    logic [WB-1:0]               beat_q, beat_d;
    logic [1:0]                  pend_err_q, pend_err_d;
    logic [1:0]                  error_q, error_d;

    logic [LINE_W-1:0]           arr [LINES];
    logic [LINE_W-1:0]           arr_rdata;
    logic                        arr_rd, arr_wr;

    logic [ADDR_W-1:0]           req_pa, inv_pa;
    logic [TAG_W-1:0]            pa_tag, rd_tag;
    logic [INDEX_BITS-1:0]       pa_idx;
    logic [WB-1:0]               pa_word;
    logic [LINE_WORDS-1:0][31:0] rd_words;
    logic                        hit;
    logic                        beat_last;
    logic [1:0]                  err_now;
    logic                        resp_vld;
    logic [31:0]                 resp_dat;
    logic                        stats_clr, hit_evt, miss_evt;

    assign req_pa   = mem_start_q + bus.req_addr;
    assign inv_pa   = mem_start_q + bus.inval_addr;
    assign pa_tag   = pa_q[ADDR_W-1 -: TAG_W];
    assign pa_idx   = pa_q[OB +: INDEX_BITS];
    assign pa_word  = pa_q[2 +: WB];
    assign rd_tag   = arr_rdata[LINE_W-1 -: TAG_W];
    assign rd_words = arr_rdata[32*LINE_WORDS-1:0];
    assign hit      = valid_q[pa_idx] && (rd_tag == pa_tag);

    always_comb begin
        state_d     = state_q;
        pa_d        = pa_q;
        mem_start_d = mem_start_q;
        valid_d     = valid_q;
        lbuf_d      = lbuf_q;
        beat_d      = beat_q;
        pend_err_d  = pend_err_q;
        error_d     = error_q;
        arr_rd      = 1'b0;
        arr_wr      = 1'b0;
        beat_last   = 1'b0;
        err_now     = 2'd0;
        resp_vld    = 1'b0;
        resp_dat    = 32'd0;
        stats_clr   = 1'b0;
        hit_evt     = 1'b0;
        miss_evt    = 1'b0;

        if (bus.mem_start_valid) begin
            mem_start_d = bus.mem_start_input;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    pa_d    = req_pa;
                    arr_rd  = 1'b1;
                    state_d = S_LOOKUP;
                end else if (bus.inval_valid) begin
                    if (bus.inval_all) begin
                        valid_d   = '0;
                        stats_clr = 1'b1;
                    end else begin
                        valid_d[inv_pa[OB +: INDEX_BITS]] = 1'b0;
                    end
                end
            end
            S_LOOKUP: begin
                if (hit) begin
                    resp_vld = 1'b1;
                    resp_dat = rd_words[pa_word];
                    hit_evt  = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    miss_evt = 1'b1;
                    state_d  = S_MISS_AR;
                end
            end
            S_MISS_AR: begin
                beat_d     = '0;
                pend_err_d = 2'd0;
                if (bus.mem_i_arready) begin
                    state_d = S_MISS_R;
                end
            end
            S_MISS_R: begin
                if (bus.mem_i_rvalid) begin
                    lbuf_d[beat_q] = bus.mem_i_rdata;
                    beat_last      = (beat_q == WB'(LINE_WORDS - 1));
                    err_now        = pend_err_q;
                    // First error seen in the burst is the one reported.
                    if (err_now == 2'd0 && bus.mem_i_rresp != 2'd0) begin
                        err_now = 2'd1;
                    end
                    if (err_now == 2'd0 && (bus.mem_i_rlast != beat_last)) begin
                        err_now = 2'd2;
                    end
                    pend_err_d = err_now;
                    beat_d     = beat_q + 1'b1;
                    if (bus.mem_i_rlast || beat_last) begin
                        if (err_now != 2'd0) begin
                            error_d = err_now;
                            state_d = S_ERROR;
                        end else begin
                            state_d = S_FILL;
                        end
                    end
                end
            end
            S_FILL: begin
                arr_wr          = 1'b1;
                valid_d[pa_idx] = 1'b1;
                resp_vld        = 1'b1;
                resp_dat        = lbuf_q[pa_word];
                state_d         = S_IDLE;
            end
            S_ERROR: begin
                state_d = S_ERROR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            pa_q        <= '0;
            mem_start_q <= '0;
            valid_q     <= '0;
            lbuf_q      <= '0;
            beat_q      <= '0;
            pend_err_q  <= 2'd0;
            error_q     <= 2'd0;
        end else begin
            state_q     <= state_d;
            pa_q        <= pa_d;
            mem_start_q <= mem_start_d;
            valid_q     <= valid_d;
            lbuf_q      <= lbuf_d;
            beat_q      <= beat_d;
            pend_err_q  <= pend_err_d;
            error_q     <= error_d;
        end
    end

    // Tag+line storage: synchronous read, whole-line write from the refill buffer.
    always_ff @(posedge clk) begin
        if (arr_wr && resetn) begin
            arr[pa_idx] <= {pa_tag, lbuf_q};
        end
        if (arr_rd) begin
            arr_rdata <= arr[req_pa[OB +: INDEX_BITS]];
        end
    end

    assign bus.req_ready     = (state_q == S_IDLE);
    assign bus.resp_valid    = resp_vld;
    assign bus.resp_data     = resp_dat;
    assign bus.error         = error_q;
    assign bus.mem_i_arvalid = (state_q == S_MISS_AR);
    assign bus.mem_i_araddr  = {pa_q[ADDR_W-1:OB], {OB{1'b0}}};
    assign bus.mem_i_arlen   = 8'(LINE_WORDS - 1);
    assign bus.mem_i_arsize  = 3'b010;
    assign bus.mem_i_arburst = 2'b01;
    assign bus.mem_i_rready  = 1'b1;

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (stats_clr) begin
            hit_cnt_d  = 32'd0;
            miss_cnt_d = 32'd0;
        end else begin
            if (hit_evt && hit_cnt_q != 32'hFFFF_FFFF) begin
                hit_cnt_d = hit_cnt_q + 32'd1;
            end
            if (miss_evt && miss_cnt_q != 32'hFFFF_FFFF) begin
                miss_cnt_d = miss_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            hit_cnt_q  <= 32'd0;
            miss_cnt_q <= 32'd0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign bus.hit_count  = hit_cnt_q;
    assign bus.miss_count = miss_cnt_q;
`else
    logic unused_stats;
    assign unused_stats = ^{stats_clr, hit_evt, miss_evt};
`endif

    logic unused_bits;
    assign unused_bits = ^{inv_pa[ADDR_W-1:OB+INDEX_BITS], inv_pa[OB-1:0], pa_q[1:0]};
endmodule

// File: tb/tb_icache_axi_param.sv
// Directed bench for icache_axi_param (INDEX_BITS=10, LINE_WORDS=16): vector table plus error/reset sequences.
module tb_icache_axi_param;
    localparam int OP_FETCH     = 0;
    localparam int OP_BASE      = 1;
    localparam int OP_INVAL     = 2;
    localparam int OP_INVAL_ALL = 3;
    localparam int NV           = 15;

    typedef struct {
        int          op;
        logic [31:0] addr;
        bit          miss;
        logic [31:0] ar;
        logic [31:0] salt;
        logic [31:0] dat;
        int          ar_dly;
    } vec_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   model_hit = 0;
    int   model_miss = 0;
    vec_t vecs [NV];

    icache_axi_param_if #(.ADDR_W(32)) bus();

    icache_axi_param #(
        .ADDR_W(32), .INDEX_BITS(10), .LINE_WORDS(16)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic chk_stats(input string nm);
`ifdef ICACHE_STATS_EN
        chk({nm, "_hit_count"}, bus.hit_count, model_hit);
        chk({nm, "_miss_count"}, bus.miss_count, model_miss);
`else
        if (nm.len() < 0) $display("%s", nm);
`endif
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        model_hit = 0;
        model_miss = 0;
    endtask

    task automatic issue(input logic [31:0] addr);
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic ar_hs(input logic [31:0] exp_ar, input int dly, input string nm);
        @(negedge clk);
        for (int d = 0; d < dly; d++) begin
            chk({nm, "_arvalid_hold"}, 32'(bus.mem_i_arvalid), 1);
            chk({nm, "_araddr_hold"}, bus.mem_i_araddr, exp_ar);
            @(negedge clk);
        end
        chk({nm, "_arvalid"}, 32'(bus.mem_i_arvalid), 1);
        chk({nm, "_araddr"}, bus.mem_i_araddr, exp_ar);
        chk({nm, "_arlen"}, 32'(bus.mem_i_arlen), 15);
        chk({nm, "_arsize"}, 32'(bus.mem_i_arsize), 2);
        chk({nm, "_arburst"}, 32'(bus.mem_i_arburst), 1);
        bus.mem_i_arready = 1'b1;
        @(negedge clk);
        bus.mem_i_arready = 1'b0;
    endtask

    task automatic beats(input int n, input logic [31:0] salt, input int last_at, input int bad_at);
        for (int i = 0; i < n; i++) begin
            bus.mem_i_rvalid = 1'b1;
            bus.mem_i_rdata  = salt + 32'(i);
            bus.mem_i_rresp  = (i == bad_at) ? 2'd2 : 2'd0;
            bus.mem_i_rlast  = (i == last_at);
            @(negedge clk);
        end
        bus.mem_i_rvalid = 1'b0;
        bus.mem_i_rlast  = 1'b0;
        bus.mem_i_rresp  = 2'd0;
    endtask

    task automatic do_fetch(input vec_t v, input string nm);
        chk({nm, "_req_ready"}, 32'(bus.req_ready), 1);
        issue(v.addr);
        if (!v.miss) begin
            chk({nm, "_hit_valid"}, 32'(bus.resp_valid), 1);
            chk({nm, "_hit_data"}, bus.resp_data, v.dat);
            chk({nm, "_hit_no_ar"}, 32'(bus.mem_i_arvalid), 0);
            model_hit++;
        end else begin
            chk({nm, "_miss_no_resp"}, 32'(bus.resp_valid), 0);
            model_miss++;
            ar_hs(v.ar, v.ar_dly, nm);
            beats(16, v.salt, 15, -1);
            chk({nm, "_fill_valid"}, 32'(bus.resp_valid), 1);
            chk({nm, "_fill_data"}, bus.resp_data, v.dat);
        end
        @(negedge clk);
        chk({nm, "_resp_pulse"}, 32'(bus.resp_valid), 0);
        chk_stats(nm);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string nm;
        nm = $sformatf("v%0d", idx);
        case (v.op)
            OP_FETCH: do_fetch(v, nm);
            OP_BASE: begin
                bus.mem_start_valid = 1'b1;
                bus.mem_start_input = v.addr;
                @(negedge clk);
                bus.mem_start_valid = 1'b0;
            end
            default: begin
                bus.inval_valid = 1'b1;
                bus.inval_all   = (v.op == OP_INVAL_ALL);
                bus.inval_addr  = v.addr;
                @(negedge clk);
                bus.inval_valid = 1'b0;
                bus.inval_all   = 1'b0;
                if (v.op == OP_INVAL_ALL) begin
                    model_hit = 0;
                    model_miss = 0;
                    chk_stats(nm);
                end
            end
        endcase
    endtask

    initial begin
        bus.req_valid = 1'b0;       bus.req_addr = '0;
        bus.inval_valid = 1'b0;     bus.inval_all = 1'b0;   bus.inval_addr = '0;
        bus.mem_start_valid = 1'b0; bus.mem_start_input = '0;
        bus.mem_i_arready = 1'b0;   bus.mem_i_rvalid = 1'b0;
        bus.mem_i_rdata = '0;       bus.mem_i_rresp = 2'd0; bus.mem_i_rlast = 1'b0;

        vecs[0]  = '{OP_BASE,      32'h0000_1000, 1'b0, 32'h0,         32'h0,   32'h0,   0};
        vecs[1]  = '{OP_FETCH,     32'h0000_0044, 1'b1, 32'h0000_1040, 32'h0,   32'h1,   0};
        vecs[2]  = '{OP_FETCH,     32'h0000_0048, 1'b0, 32'h0,         32'h0,   32'h2,   0};
        vecs[3]  = '{OP_FETCH,     32'h0001_0044, 1'b1, 32'h0001_1040, 32'h100, 32'h101, 2};
        vecs[4]  = '{OP_FETCH,     32'h0000_0044, 1'b1, 32'h0000_1040, 32'h0,   32'h1,   0};
        vecs[5]  = '{OP_FETCH,     32'h0000_007C, 1'b0, 32'h0,         32'h0,   32'hF,   0};
        vecs[6]  = '{OP_INVAL,     32'h0000_0040, 1'b0, 32'h0,         32'h0,   32'h0,   0};
        vecs[7]  = '{OP_FETCH,     32'h0000_0044, 1'b1, 32'h0000_1040, 32'h10,  32'h11,  0};
        vecs[8]  = '{OP_FETCH,     32'h0000_0080, 1'b1, 32'h0000_1080, 32'h20,  32'h20,  0};
        vecs[9]  = '{OP_FETCH,     32'h0000_0040, 1'b0, 32'h0,         32'h0,   32'h10,  0};
        vecs[10] = '{OP_INVAL_ALL, 32'h0,         1'b0, 32'h0,         32'h0,   32'h0,   0};
        vecs[11] = '{OP_FETCH,     32'h0000_0084, 1'b1, 32'h0000_1080, 32'h30,  32'h31,  0};
        vecs[12] = '{OP_BASE,      32'hFFFF_FFC0, 1'b0, 32'h0,         32'h0,   32'h0,   0};
        vecs[13] = '{OP_FETCH,     32'h0000_0084, 1'b1, 32'h0000_0040, 32'h40,  32'h41,  0};
        vecs[14] = '{OP_FETCH,     32'h0000_0088, 1'b0, 32'h0,         32'h0,   32'h42,  0};

        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        chk("rst_req_ready", 32'(bus.req_ready), 1);
        chk("rst_resp_valid", 32'(bus.resp_valid), 0);
        chk("rst_resp_data", bus.resp_data, 0);
        chk("rst_error", 32'(bus.error), 0);
        chk("rst_arvalid", 32'(bus.mem_i_arvalid), 0);
        chk("rst_rready", 32'(bus.mem_i_rready), 1);
        chk_stats("rst");

        for (int i = 0; i < NV; i++) begin
            run_vec(vecs[i], i);
        end

        // RRESP error on beat 5: reported once the burst completes, then locked out.
        do_reset();
        issue(32'h44);
        ar_hs(32'h40, 0, "rresp");
        beats(16, 32'h0, 15, 5);
        chk("rresp_error", 32'(bus.error), 1);
        chk("rresp_ready", 32'(bus.req_ready), 0);
        chk("rresp_no_resp", 32'(bus.resp_valid), 0);
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h80;
        repeat (3) @(negedge clk);
        bus.req_valid = 1'b0;
        chk("err_lock_arvalid", 32'(bus.mem_i_arvalid), 0);
        chk("err_lock_resp", 32'(bus.resp_valid), 0);
        chk("err_lock_error", 32'(bus.error), 1);
        chk("err_lock_ready", 32'(bus.req_ready), 0);
        do_reset();
        chk("err_clr_error", 32'(bus.error), 0);
        chk("err_clr_ready", 32'(bus.req_ready), 1);

        // Early rlast on beat 8: burst-length error.
        issue(32'h44);
        ar_hs(32'h40, 0, "short");
        beats(9, 32'h0, 8, -1);
        chk("short_error", 32'(bus.error), 2);
        chk("short_ready", 32'(bus.req_ready), 0);
        chk("short_no_resp", 32'(bus.resp_valid), 0);
        do_reset();

        // Reset after 4 beats, then the remaining 12 beats arrive while idle.
        issue(32'h44);
        ar_hs(32'h40, 0, "abort");
        beats(4, 32'h0, -1, -1);
        do_reset();
        beats(12, 32'h99, 11, -1);
        chk("stray_arvalid", 32'(bus.mem_i_arvalid), 0);
        chk("stray_resp", 32'(bus.resp_valid), 0);
        chk("stray_ready", 32'(bus.req_ready), 1);
        chk("stray_error", 32'(bus.error), 0);
        do_fetch('{OP_FETCH, 32'h44, 1'b1, 32'h40, 32'h50, 32'h51, 0}, "post_abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/icache_axi_param.md
# icache_axi_param

Parametrised, direct-mapped instruction cache that replaces the fixed 64-byte-line, 1024-line instruction fetch cache. It sits between the pipeline fetch stage and the AXI instruction port of main memory. It refills whole lines with one AXI INCR burst and relocates every fetch by the `mem_start` base. It adds explicit line and whole-cache invalidation, a registered request/response handshake, and reset.

## Interface
- `ADDR_W`, 32: address width; data width is fixed at 32.
- `INDEX_BITS`, 10: number of lines is 2^INDEX_BITS.
- `LINE_WORDS`, 16: words per line; power of two, 2..256. Offset bits are OB = log2(LINE_WORDS)+2. Tag width is ADDR_W-INDEX_BITS-OB.
- `clk` in 1: single clock, rising edge.
- `resetn` in 1: synchronous, active-low reset.
- `req_valid` in 1, `req_ready` out 1, `req_addr` in ADDR_W: fetch request; the address is a byte address relative to `mem_start`.
- `resp_valid` out 1, `resp_data` out 32: fetched word. `resp_valid` is a single-cycle pulse; there is no backpressure.
- `inval_valid` in 1, `inval_all` in 1, `inval_addr` in ADDR_W: invalidate request. `inval_addr` is relative to `mem_start`.
- `mem_start_valid` in 1, `mem_start_input` in ADDR_W: relocation base load.
- `error` out 2: 0 = ok, 1 = AXI RRESP error, 2 = burst-length error. Sticky.
- `mem_i_arvalid` out 1, `mem_i_arready` in 1, `mem_i_araddr` out ADDR_W, `mem_i_arlen` out 8, `mem_i_arsize` out 3, `mem_i_arburst` out 2: AXI read address channel.
- `mem_i_rvalid` in 1, `mem_i_rready` out 1, `mem_i_rdata` in 32, `mem_i_rresp` in 2, `mem_i_rlast` in 1: AXI read data channel.
- `hit_count` out 32, `miss_count` out 32: present only with `ICACHE_STATS_EN`.

## Operation
- Physical address is PA = `mem_start` + `req_addr`, computed with ADDR_W-bit modular addition. PA is split into tag | index | word | byte. The byte bits are ignored, so the fetch is word-aligned.
- Storage:
  - Valid bits are held in a 2^INDEX_BITS flop vector.
  - Tag and line data are held in a synchronous-read array: write on the clock edge, read data valid the next cycle.
- States:
  - IDLE: `req_ready`=1. If `req_valid` is high, latch PA, start the array read, and go to LOOKUP. Otherwise, if `inval_valid` is high, apply the invalidate and stay in IDLE. A request takes priority over an invalidate in the same cycle; `inval_valid` must be held until IDLE with no request.
  - LOOKUP:
    - Hit (valid && tag match): `resp_valid`=1, `resp_data` = the selected word, go to IDLE.
    - Miss: go to MISS_AR.
  - MISS_AR: assert `mem_i_arvalid` with `araddr` = {PA[ADDR_W-1:OB], OB'b0}, `arlen` = LINE_WORDS-1, `arsize` = 3'b010, `arburst` = 2'b01. Hold these until `arready`, then go to MISS_R.
  - MISS_R:
    - Each R beat is written into the line buffer at beat index k, then k is incremented.
    - If `rresp` is nonzero on any beat, `error`=1.
    - If `rlast` arrives with k != LINE_WORDS-1, or k reaches LINE_WORDS-1 without `rlast`, `error`=2.
    - Either error moves the block to ERROR once the burst ends, i.e. after the beat with `rlast` or beat LINE_WORDS, whichever comes first.
    - Otherwise the last beat moves the block to FILL.
  - FILL:
    - Write {tag, buffer} into the array and set the valid bit.
    - `resp_valid`=1 with the requested word, taken from the buffer rather than the array.
    - Go to IDLE.
  - ERROR: `req_ready`=0 and all requests are ignored. The block leaves ERROR only on reset.
- Invalidate:
  - With `inval_all`=1, all valid bits are cleared in one cycle.
  - Otherwise the valid bit at index (`mem_start`+`inval_addr`).index is cleared, without a tag check.
- A `mem_start` load takes effect the cycle after `mem_start_valid`. Requests already latched keep their PA.
- `mem_i_rready` is constantly 1. R beats arriving outside MISS_R are discarded, which drains bursts left over from a reset taken mid-miss.

## Timing
- Hit latency: request accepted in cycle N, `resp_valid` in cycle N+1. Back-to-back hits give one word every 2 cycles.
- Miss latency: AR is asserted in cycle N+2. The response comes 1 cycle after the last R beat (in FILL).
- Reset values:
  - state = IDLE, `req_ready`=1, `resp_valid`=0, `resp_data`=0, `error`=0.
  - `mem_i_arvalid`=0, `mem_i_rready`=1, `mem_start`=0, all valid bits = 0, counters = 0.
- Reset mid-operation aborts the miss; no line is written.
- Address wrap: PA wraps modulo 2^ADDR_W. There is no fault on overflow.

## Configuration
- `ICACHE_STATS_EN` defined:
  - Adds the `hit_count` and `miss_count` outputs.
  - Each counter increments once per LOOKUP outcome and saturates at 32'hFFFF_FFFF.
  - Both counters clear on reset and on an `inval_all` invalidate.
- `ICACHE_STATS_EN` undefined: the ports and counters are absent and the logic is otherwise identical.

## Test plan
- Cold miss: `mem_start`=0x1000, fetch 0x44 (LINE_WORDS=16) -> `araddr`=0x1040, `arlen`=15. The 16-beat burst returns data = beat index. `resp_data`=1 one cycle after `rlast`.
- Hit: refetch 0x48 -> `resp_valid` at N+1 with data 2 and no AR. Stats build: `hit_count`=1, `miss_count`=1.
- Conflict: fetch 0x44, then 0x10044 (INDEX_BITS=10) -> two misses. A third fetch of 0x44 misses again.
- Invalidate: after a hit on 0x44, line invalidate of 0x40 -> the next fetch of 0x44 issues an AR. `inval_all` clears all lines and the counters.
- Errors: `rresp`=2 on beat 5 -> `error`=1 after the final beat and `req_ready`=0 until `resetn`. `rlast` on beat 8 -> `error`=2.
- Reset during MISS_R after 4 beats, then 12 stray beats -> beats are ignored, `arvalid`=0, and the next fetch misses cleanly.
